// File: rtl/memory_port_arbiter_pkg.sv
// rtl/memory_port_arbiter_pkg.sv - shared types and defaults for the memory port arbiter
package memory_arbiter_params;

  localparam int DEFAULT_MAX_OUTSTANDING = 4;
  localparam int DEFAULT_STARVE_LIMIT    = 8;

  typedef enum logic {
    REQ_INST = 1'b0,
    REQ_DATA = 1'b1
  } RequesterId;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } MemRequest;

endpackage

// File: rtl/memory_port_arbiter_id_fifo.sv
// rtl/memory_port_arbiter_id_fifo.sv - in-order FIFO of requester IDs for in-flight transactions
module id_fifo
  import memory_arbiter_params::*;
#(
  parameter int DEPTH = DEFAULT_MAX_OUTSTANDING,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  RequesterId    push_id,
  input  logic          pop,
  output RequesterId    head_id,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  RequesterId      mem_q [DEPTH];
  RequesterId      mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head_id = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so the pointers wrap on natural overflow
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= REQ_INST;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - shares one sram-like port between inst fetch and data access
module memory_port_arbiter
  import memory_arbiter_params::*;
#(
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int STARVE_LIMIT    = DEFAULT_STARVE_LIMIT,
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inst_req,
  input  logic          inst_wr,
  input  logic [1:0]    inst_size,
  input  logic [31:0]   inst_addr,
  input  logic [31:0]   inst_wdata,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [31:0]   inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [31:0]   data_addr,
  input  logic [31:0]   data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [31:0]   data_rdata,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [1:0]    mem_size,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [31:0]   mem_rdata,
  output logic [CW-1:0] outstanding_count,
  output logic          protocol_error
);

  logic        lock_q, lock_d;
  RequesterId  lock_id_q, lock_id_d;
  logic [7:0]  starve_q, starve_d;
  logic        perr_q, perr_d;

  RequesterId  grant, head_id;
  MemRequest   inst_rq, data_rq, grant_rq;
  logic        grant_req, req_ok, inst_aok, data_aok;
  logic        full, empty, push, pop, starve_at_limit;

  assign starve_at_limit = (starve_q == 8'(STARVE_LIMIT));

  id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .push_id (grant),
    .pop     (pop),
    .head_id (head_id),
    .full    (full),
    .empty   (empty),
    .count   (outstanding_count)
  );

  always_comb begin
    inst_rq = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
    data_rq = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

    // A stalled request keeps the port until accepted, so fields stay coherent downstream
    if (lock_q) begin
      grant = lock_id_q;
    end else if (inst_req && (!data_req || starve_at_limit)) begin
      grant = REQ_INST;
    end else begin
      grant = REQ_DATA;
    end

    grant_rq  = (grant == REQ_INST) ? inst_rq : data_rq;
    grant_req = (grant == REQ_INST) ? inst_req : data_req;
    req_ok    = grant_req && !full;
    inst_aok  = req_ok && mem_addr_ok && (grant == REQ_INST);
    data_aok  = req_ok && mem_addr_ok && (grant == REQ_DATA);
    push      = req_ok && mem_addr_ok;
    pop       = mem_data_ok && !empty;

    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    starve_d  = starve_q;
    if (!full) begin
      lock_d    = req_ok && !mem_addr_ok;
      lock_id_d = grant;
      if (inst_req && !inst_aok) begin
        starve_d = starve_at_limit ? starve_q : starve_q + 8'd1;
      end else begin
        starve_d = 8'd0;
      end
    end

    perr_d = perr_q || (mem_data_ok && empty);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lock_id_q <= REQ_INST;
      starve_q  <= 8'd0;
      perr_q    <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      starve_q  <= starve_d;
      perr_q    <= perr_d;
    end
  end

  // Outputs are held at zero for the whole reset window, not just after the edge
  assign mem_req        = req_ok && !reset;
  assign mem_wr         = grant_rq.wr && !reset;
  assign mem_size       = reset ? 2'b00 : grant_rq.size;
  assign mem_addr       = reset ? 32'd0 : grant_rq.addr;
  assign mem_wdata      = reset ? 32'd0 : grant_rq.wdata;
  assign inst_addr_ok   = inst_aok && !reset;
  assign data_addr_ok   = data_aok && !reset;
  assign inst_data_ok   = pop && (head_id == REQ_INST) && !reset;
  assign data_data_ok   = pop && (head_id == REQ_DATA) && !reset;
  assign inst_rdata     = reset ? 32'd0 : mem_rdata;
  assign data_rdata     = reset ? 32'd0 : mem_rdata;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - randomized and directed bench for memory_port_arbiter
module tb_memory_port_arbiter;

  localparam int MAXO = 4;
  localparam int LIM  = 8;
  localparam int ID_I = 0;
  localparam int ID_D = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  outstanding_count;
  logic        protocol_error;

  int checks = 0;
  int failures = 0;

  // Reference model: transactions in issue order, starvation age, lock owner
  int q[$];
  int m_starve;
  bit m_lock;
  int m_lock_id;
  int e_grant;
  bit e_mem_req, e_iaok, e_daok, e_idok, e_ddok;

  always #5 clock = ~clock;

  memory_port_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .outstanding_count(outstanding_count),
    .protocol_error(protocol_error)
  );

  task automatic model_eval();
    bit full;
    bit greq;
    full = (q.size() == MAXO);
    if (m_lock) e_grant = m_lock_id;
    else if (inst_req && (!data_req || m_starve == LIM)) e_grant = ID_I;
    else e_grant = ID_D;
    greq      = (e_grant == ID_I) ? inst_req : data_req;
    e_mem_req = !full && greq;
    e_iaok    = e_mem_req && mem_addr_ok && (e_grant == ID_I);
    e_daok    = e_mem_req && mem_addr_ok && (e_grant == ID_D);
    e_idok    = mem_data_ok && (q.size() > 0) && (q[0] == ID_I);
    e_ddok    = mem_data_ok && (q.size() > 0) && (q[0] == ID_D);
  endtask

  task automatic model_commit();
    bit full;
    full = (q.size() == MAXO);
    if (mem_data_ok && q.size() > 0) void'(q.pop_front());
    if (e_mem_req && mem_addr_ok) q.push_back(e_grant);
    if (!full) begin
      m_lock    = e_mem_req && !mem_addr_ok;
      m_lock_id = e_grant;
      if (inst_req && !e_iaok) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
      else m_starve = 0;
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clock);
    model_commit();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic apply_reset();
    reset = 1;
    clear_inputs();
    q.delete(); m_starve = 0; m_lock = 0; m_lock_id = 0;
    repeat (2) @(negedge clock);
    reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, protocol_error} !== 6'b0
        || outstanding_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: flags=%b count=%0d, want all 0", {mem_req, inst_addr_ok,
               data_addr_ok, inst_data_ok, data_data_ok, protocol_error}, outstanding_count);
    end
  endtask

  task automatic test_priority();
    logic [31:0] r;
    apply_reset();
    inst_req = 1; inst_addr = 32'h1000; data_req = 1; data_addr = 32'h2000; mem_addr_ok = 1;
    #1;
    checks++;
    if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0 || mem_addr !== 32'h2000) begin
      failures++;
      $display("FAIL priority_grant: data_aok=%b inst_aok=%b addr=%h, want 1 0 2000",
               data_addr_ok, inst_addr_ok, mem_addr);
    end
    tick();
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; r = $urandom; mem_rdata = r;
    #1;
    checks++;
    if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== r) begin
      failures++;
      $display("FAIL priority_head: data_dok=%b inst_dok=%b rdata=%h, want 1 0 %h",
               data_data_ok, inst_data_ok, data_rdata, r);
    end
    tick();
  endtask

  task automatic test_starve();
    apply_reset();
    inst_req = 1; inst_addr = 32'hA0; data_req = 1; data_addr = 32'hB0; mem_addr_ok = 1;
    for (int c = 1; c <= 12; c++) begin
      mem_data_ok = (q.size() > 0);
      #1;
      checks++;
      if (inst_addr_ok !== (c == 9) || data_addr_ok !== (c != 9)) begin
        failures++;
        $display("FAIL starve_cycle%0d: inst_aok=%b data_aok=%b, want %b %b", c,
                 inst_addr_ok, data_addr_ok, c == 9, c != 9);
      end
      tick();
    end
  endtask

  task automatic test_lock();
    apply_reset();
    data_req = 1; data_addr = $urandom; inst_addr = $urandom;
    for (int c = 0; c < 4; c++) begin
      inst_req = (c >= 1); mem_addr_ok = (c == 3);
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== data_addr || inst_addr_ok !== 1'b0
          || data_addr_ok !== (c == 3)) begin
        failures++;
        $display("FAIL lock_cycle%0d: req=%b addr=%h data_aok=%b inst_aok=%b, want 1 %h %b 0",
                 c, mem_req, mem_addr, data_addr_ok, inst_addr_ok, data_addr, c == 3);
      end
      tick();
    end
    data_req = 0;
    #1;
    checks++;
    if (mem_addr !== inst_addr || inst_addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL lock_release: addr=%h inst_aok=%b, want %h 1", mem_addr, inst_addr_ok,
               inst_addr);
    end
    tick();
  endtask

  task automatic test_full_order();
    int seq[4] = '{ID_I, ID_D, ID_D, ID_I};
    logic [31:0] r;
    apply_reset();
    mem_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      inst_req = (seq[k] == ID_I); data_req = (seq[k] == ID_D);
      tick();
    end
    inst_req = 1; data_req = 1;
    #1;
    checks++;
    if (outstanding_count !== 3'd4 || mem_req !== 1'b0 || inst_addr_ok !== 1'b0
        || data_addr_ok !== 1'b0) begin
      failures++;
      $display("FAIL full_block: count=%0d req=%b aok=%b%b, want 4 0 00", outstanding_count,
               mem_req, inst_addr_ok, data_addr_ok);
    end
    tick();
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    for (int k = 0; k < 4; k++) begin
      mem_data_ok = 1; r = $urandom; mem_rdata = r;
      #1;
      checks++;
      if ({inst_data_ok, data_data_ok} !== ((seq[k] == ID_I) ? 2'b10 : 2'b01)
          || inst_rdata !== r || data_rdata !== r) begin
        failures++;
        $display("FAIL order_resp%0d: dok(i,d)=%b%b rdata=%h, want id %0d rdata %h", k,
                 inst_data_ok, data_data_ok, inst_rdata, seq[k], r);
      end
      tick();
    end
    mem_data_ok = 0;
    #1;
    checks++;
    if (outstanding_count !== 3'd0) begin
      failures++;
      $display("FAIL order_drain: count=%0d, want 0", outstanding_count);
    end
  endtask

  task automatic test_push_pop();
    int want_head;
    apply_reset();
    mem_addr_ok = 1;
    data_req = 1; tick();
    data_req = 0; inst_req = 1; tick();
    for (int k = 0; k < 7; k++) begin
      want_head = (k == 0) ? ID_D : q[0];
      inst_req = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      data_req = !inst_req;
      mem_data_ok = 1;
      #1;
      checks++;
      if ({inst_data_ok, data_data_ok} !== ((want_head == ID_I) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL pushpop_route%0d: dok(i,d)=%b%b, want head %0d", k, inst_data_ok,
                 data_data_ok, want_head);
      end
      tick();
      #1;
      checks++;
      if (outstanding_count !== 3'd2) begin
        failures++;
        $display("FAIL pushpop_count%0d: count=%0d, want 2", k, outstanding_count);
      end
    end
  endtask

  task automatic test_protocol_error();
    apply_reset();
    mem_data_ok = 1;
    #1;
    checks++;
    if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
      failures++;
      $display("FAIL perr_nodok: dok(i,d)=%b%b, want 00", inst_data_ok, data_data_ok);
    end
    tick();
    mem_data_ok = 0; data_req = 1; mem_addr_ok = 1;
    #1;
    checks++;
    if (protocol_error !== 1'b1 || outstanding_count !== 3'd0) begin
      failures++;
      $display("FAIL perr_set: perr=%b count=%0d, want 1 0", protocol_error, outstanding_count);
    end
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; tick();
    mem_data_ok = 0;
    #1;
    checks++;
    if (protocol_error !== 1'b1) begin
      failures++;
      $display("FAIL perr_sticky: perr=%b, want 1", protocol_error);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    data_req = 1; mem_addr_ok = 1;
    repeat (3) tick();
    inst_req = 1; mem_data_ok = 1; mem_rdata = $urandom | 32'h1; inst_addr = 32'h55;
    #2;
    reset = 1;
    #1;
    checks++;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, protocol_error} !== 6'b0
        || outstanding_count !== 3'd0 || inst_rdata !== 32'd0 || mem_addr !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: flags=%b count=%0d rdata=%h addr=%h, want all 0", {mem_req,
               inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, protocol_error},
               outstanding_count, inst_rdata, mem_addr);
    end
    apply_reset();
  endtask

  task automatic test_random();
    bit last_iaok = 0, last_daok = 0;
    logic [31:0] want_addr, want_wdata;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if (!(inst_req && !last_iaok)) begin
        inst_req = ($urandom_range(0, 2) != 0); inst_wr = 1'($urandom); inst_addr = $urandom;
        inst_size = 2'($urandom_range(0, 2)); inst_wdata = $urandom;
      end
      if (!(data_req && !last_daok)) begin
        data_req = ($urandom_range(0, 2) != 0); data_wr = 1'($urandom); data_addr = $urandom;
        data_size = 2'($urandom_range(0, 2)); data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 3) != 0);
      mem_data_ok = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      mem_rdata   = $urandom;
      #1;
      model_eval();
      want_addr  = (e_grant == ID_I) ? inst_addr : data_addr;
      want_wdata = (e_grant == ID_I) ? inst_wdata : data_wdata;
      checks++;
      if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !==
          {e_mem_req, e_iaok, e_daok, e_idok, e_ddok}) begin
        failures++;
        $display("FAIL rand_flags c%0d: req,aok,dok=%b, want %b", c, {mem_req, inst_addr_ok,
                 data_addr_ok, inst_data_ok, data_data_ok}, {e_mem_req, e_iaok, e_daok,
                 e_idok, e_ddok});
      end
      checks++;
      if (int'(outstanding_count) !== q.size() || protocol_error !== 1'b0) begin
        failures++;
        $display("FAIL rand_count c%0d: count=%0d perr=%b, want %0d 0", c, outstanding_count,
                 protocol_error, q.size());
      end
      if (e_mem_req) begin
        checks++;
        if (mem_addr !== want_addr || mem_wdata !== want_wdata) begin
          failures++;
          $display("FAIL rand_fields c%0d: addr=%h wdata=%h, want %h %h", c, mem_addr,
                   mem_wdata, want_addr, want_wdata);
        end
      end
      if (mem_data_ok) begin
        checks++;
        if (inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin
          failures++;
          $display("FAIL rand_rdata c%0d: i=%h d=%h, want %h", c, inst_rdata, data_rdata,
                   mem_rdata);
        end
      end
      last_iaok = e_iaok;
      last_daok = e_daok;
      tick();
    end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    @(negedge clock);
    test_reset();
    test_priority();
    test_starve();
    test_lock();
    test_full_order();
    test_push_pop();
    test_protocol_error();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
